// File: rtl/uart_rx_deframer.sv
// 8N1 UART receive deframer: runs on clk, advances on rising edges of the x16
// oversample clock, votes 3 mid-bit samples and hands bytes out via valid/ack.
module uart_rx_deframer #(
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLE   = 16,
  parameter int TICK_CNT_BIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_X16_Sample_Clk,
  input  logic                 i_Rx,
  input  logic                 i_Rx_Ack,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Rx_Valid,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun
);

  localparam int BIT_CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_CNT_BIT-1:0] TICK_S7   = TICK_CNT_BIT'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_CNT_BIT-1:0] TICK_S8   = TICK_CNT_BIT'(OVERSAMPLE / 2);
  localparam logic [TICK_CNT_BIT-1:0] TICK_S9   = TICK_CNT_BIT'(OVERSAMPLE / 2 + 1);
  localparam logic [TICK_CNT_BIT-1:0] TICK_LAST = TICK_CNT_BIT'(OVERSAMPLE - 1);
  localparam logic [BIT_CNT_W-1:0]    BIT_LAST  = BIT_CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [TICK_CNT_BIT-1:0] tick_cnt;
  logic [TICK_CNT_BIT-1:0] tick_cnt_nxt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt_nxt;
  logic                  s7;
  logic                  s7_nxt;
  logic                  s8;
  logic                  s8_nxt;
  logic [DATA_BITS-1:0]  shift_reg;
  logic [DATA_BITS-1:0]  shift_nxt;

  logic rx_meta;
  logic rxs;
  logic x16_meta;
  logic x16_sync;
  logic x16_prev;
  logic tick;
  logic maj;
  logic load;
  logic frame_err_nxt;

  // Both asynchronous inputs see the same two-flop depth, so a line change
  // made together with an x16 rising edge is visible on that edge's tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      x16_meta <= 1'b0;
      x16_sync <= 1'b0;
      x16_prev <= 1'b0;
    end else begin
      rx_meta  <= i_Rx;
      rxs      <= rx_meta;
      x16_meta <= i_X16_Sample_Clk;
      x16_sync <= x16_meta;
      x16_prev <= x16_sync;
    end
  end

  assign tick = x16_sync & ~x16_prev;

  // The third vote is taken live from rxs on the tick_cnt = 9 tick.
  assign maj = (s7 & s8) | (s7 & rxs) | (s8 & rxs);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      s7        <= 1'b0;
      s8        <= 1'b0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      s7        <= s7_nxt;
      s8        <= s8_nxt;
      shift_reg <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    tick_cnt_nxt  = tick_cnt;
    bit_cnt_nxt   = bit_cnt;
    s7_nxt        = s7;
    s8_nxt        = s8;
    shift_nxt     = shift_reg;
    load          = 1'b0;
    frame_err_nxt = 1'b0;

    if (tick) begin
      if (state != IDLE) begin
        tick_cnt_nxt = tick_cnt + 1'b1;
        if (tick_cnt == TICK_S7) s7_nxt = rxs;
        if (tick_cnt == TICK_S8) s8_nxt = rxs;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state_nxt    = START;
            tick_cnt_nxt = '0;
          end
        end
        START: begin
          if (tick_cnt == TICK_S9 && maj) begin
            state_nxt    = IDLE;
            tick_cnt_nxt = '0;
          end else if (tick_cnt == TICK_LAST) begin
            state_nxt    = DATA;
            tick_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
          end
        end
        DATA: begin
          if (tick_cnt == TICK_S9) begin
            shift_nxt = {maj, shift_reg[DATA_BITS-1:1]};
          end
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_nxt = '0;
            if (bit_cnt == BIT_LAST) begin
              state_nxt = STOP;
            end else begin
              bit_cnt_nxt = bit_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          if (tick_cnt == TICK_S9) begin
            state_nxt    = IDLE;
            tick_cnt_nxt = '0;
            if (maj) begin
              load = 1'b1;
            end else begin
              frame_err_nxt = 1'b1;
            end
          end
        end
        default: begin
          state_nxt    = IDLE;
          tick_cnt_nxt = '0;
        end
      endcase
    end
  end

  // A load that lands while the consumer acks in the same cycle counts as
  // consumed-then-refilled, so it never raises overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_Rx_Data   <= '0;
      o_Rx_Valid  <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Overrun   <= 1'b0;
    end else begin
      o_Frame_Err <= frame_err_nxt;
      if (load) begin
        o_Rx_Data  <= shift_reg;
        o_Rx_Valid <= 1'b1;
        if (i_Rx_Ack) begin
          o_Overrun <= 1'b0;
        end else if (o_Rx_Valid) begin
          o_Overrun <= 1'b1;
        end
      end else if (i_Rx_Ack) begin
        o_Rx_Valid <= 1'b0;
        o_Overrun  <= 1'b0;
      end
    end
  end

endmodule
